// File: rtl/lcd_arb_pkg.sv
// Shared types and helpers for the LCD character bus arbiter.
// Optional feature macro: LCD_BUSY_WAIT_EN (adds the WAIT state).
package lcd_arb_pkg;

   localparam int CHAR_W = 7;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      WAIT
   } lcd_state_t;

   // Width that holds the longest phase length without wrapping.
   function automatic int cnt_width(input int s, input int p, input int h);
      int m;
      m = s;
      if (p > m) m = p;
      if (h > m) m = h;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Phase counter for the LCD strobe sequence; flags the last cycle of each timed phase.
// Optional feature macro: LCD_BUSY_WAIT_EN (WAIT is untimed, never flags done).
module lcd_strobe_timer
   import lcd_arb_pkg::*;
#(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int HOLD_CYC  = 2,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  lcd_state_t       state,
   input  logic             restart,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (restart) begin
         count_reg <= '0;
      end else if (count_reg != '1) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   always_comb begin
      done = 1'b0;
      case (state)
         SETUP:   done = (count_reg == CNT_W'(SETUP_CYC - 1));
         PULSE:   done = (count_reg == CNT_W'(PULSE_CYC - 1));
         HOLD:    done = (count_reg == CNT_W'(HOLD_CYC - 1));
         default: done = 1'b0;
      endcase
   end

   assign count = count_reg;

endmodule

// File: rtl/lcd_char_arbiter.sv
// Round-robin arbiter for the shared LCD character bus with timed enable strobe.
// Optional feature macro: LCD_BUSY_WAIT_EN (lcd_busy input, WAIT state after HOLD).
module lcd_char_arbiter
   import lcd_arb_pkg::*;
#(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int HOLD_CYC  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [CHAR_W-1:0] data0,
   output logic              ack0,
   input  logic              req1,
   input  logic [CHAR_W-1:0] data1,
   output logic              ack1,
   output logic              mux_sel,
   output logic [CHAR_W-1:0] lcd_data,
   output logic              lcd_en,
`ifdef LCD_BUSY_WAIT_EN
   input  logic              lcd_busy,
`endif
   output logic              busy
);

   localparam int CNT_W = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

   lcd_state_t        state_reg, state_next;
   logic              last_grant_reg;
   logic              mux_sel_reg;
   logic [CHAR_W-1:0] lcd_data_reg;
   logic              lcd_en_reg;
   logic              grant, winner, restart, done;
   logic [CNT_W-1:0]  count;
   logic [CHAR_W-1:0] sel_data;

   // 7-bit 2:1 character mux, steered by the arbitration winner.
   for (genvar gi = 0; gi < CHAR_W; gi++) begin : g_char_mux
      assign sel_data[gi] = winner ? data1[gi] : data0[gi];
   end

   lcd_strobe_timer #(
      .SETUP_CYC (SETUP_CYC),
      .PULSE_CYC (PULSE_CYC),
      .HOLD_CYC  (HOLD_CYC),
      .CNT_W     (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .state   (state_reg),
      .restart (restart),
      .count   (count),
      .done    (done)
   );

   always_comb begin
      state_next = state_reg;
      grant      = req0 | req1;
      winner     = (req0 & req1) ? ~last_grant_reg : req1;
      case (state_reg)
         IDLE:  if (grant) state_next = SETUP;
         SETUP: if (done)  state_next = PULSE;
         PULSE: if (done)  state_next = HOLD;
`ifdef LCD_BUSY_WAIT_EN
         HOLD:  if (done)  state_next = WAIT;
         WAIT:  if (!lcd_busy) state_next = IDLE;
`else
         HOLD:  if (done)  state_next = IDLE;
`endif
         default: state_next = IDLE;
      endcase
      restart = (state_next != state_reg);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         mux_sel_reg    <= 1'b0;
         lcd_data_reg   <= '0;
         lcd_en_reg     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         lcd_en_reg <= (state_next == PULSE);
         if (state_reg == IDLE && grant) begin
            mux_sel_reg    <= winner;
            lcd_data_reg   <= sel_data;
            last_grant_reg <= winner;
         end
      end
   end

`ifdef LCD_BUSY_WAIT_EN
   // Ack must land in the very cycle lcd_busy is seen low, so it is decoded from WAIT.
   assign ack0 = (state_reg == WAIT) & ~lcd_busy & ~last_grant_reg;
   assign ack1 = (state_reg == WAIT) & ~lcd_busy &  last_grant_reg;
`else
   logic ack0_reg, ack1_reg, hold_last_next;

   // True when the coming cycle is the final HOLD cycle.
   assign hold_last_next = (state_reg == PULSE && done && HOLD_CYC == 1) ||
                           (state_reg == HOLD && int'(count) + 2 == HOLD_CYC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack0_reg <= 1'b0;
         ack1_reg <= 1'b0;
      end else begin
         ack0_reg <= hold_last_next & ~last_grant_reg;
         ack1_reg <= hold_last_next &  last_grant_reg;
      end
   end

   assign ack0 = ack0_reg;
   assign ack1 = ack1_reg;
`endif

   assign mux_sel  = mux_sel_reg;
   assign lcd_data = lcd_data_reg;
   assign lcd_en   = lcd_en_reg;
   assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_lcd_char_arbiter.sv
// Directed self-checking bench for lcd_char_arbiter (default timing 2/4/2).
// Optional feature macro: LCD_BUSY_WAIT_EN enables the lcd_busy scenario.
module tb_lcd_char_arbiter;

`ifdef LCD_BUSY_WAIT_EN
   localparam int ACK_C = 9;
`else
   localparam int ACK_C = 8;
`endif
   localparam int TL = ACK_C + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [6:0] data0 = '0, data1 = '0;
   logic       ack0, ack1, mux_sel, lcd_en, busy;
   logic [6:0] lcd_data;
`ifdef LCD_BUSY_WAIT_EN
   logic       lcd_busy = 1'b0;
`endif

   int checks = 0;
   int passed = 0;
   logic [11:0] obs, expv;

   assign obs = {busy, lcd_en, ack1, ack0, mux_sel, lcd_data};

   lcd_char_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .data0    (data0),
      .ack0     (ack0),
      .req1     (req1),
      .data1    (data1),
      .ack1     (ack1),
      .mux_sel  (mux_sel),
      .lcd_data (lcd_data),
      .lcd_en   (lcd_en),
`ifdef LCD_BUSY_WAIT_EN
      .lcd_busy (lcd_busy),
`endif
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Expected {busy,lcd_en,ack1,ack0,mux_sel,lcd_data} in cycle p after the grant edge.
   function automatic logic [11:0] txn_exp(input int p, input logic s, input logic [6:0] d);
      logic b, e, a;
      b = (p <= ACK_C);
      e = (p >= 3 && p <= 6);
      a = (p == ACK_C);
      return {b, e, a & s, a & ~s, s, d};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++;
      if (obs !== 12'h000) $display("FAIL reset_hold got %h exp %h", obs, 12'h000);
      else passed++;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if (obs !== 12'h000) $display("FAIL reset_release got %h exp %h", obs, 12'h000);
      else passed++;
      $display("txn reset: outputs %h", obs);
   endtask

   task automatic test_simultaneous();
      req0 = 1'b1; req1 = 1'b1; data0 = 7'h06; data1 = 7'h5B;
      for (int c = 1; c <= 2 * TL; c++) begin
         @(posedge clk); #1;
         if (c == TL)     req0 = 1'b0;
         if (c == 2 * TL) req1 = 1'b0;
         #1;
         expv = (c <= TL) ? txn_exp(c, 1'b0, 7'h06) : txn_exp(c - TL, 1'b1, 7'h5B);
         checks++;
         if (obs !== expv) $display("FAIL simultaneous c%0d got %h exp %h", c, obs, expv);
         else passed++;
         if (c % TL == 0) $display("txn simultaneous #%0d: sel=%0d data=%h", c / TL, mux_sel, lcd_data);
      end
   endtask

   task automatic test_fairness();
      req0 = 1'b1; req1 = 1'b1; data0 = 7'h06; data1 = 7'h5B;
      for (int c = 1; c <= 4 * TL; c++) begin
         int t, p;
         logic s;
         t = (c - 1) / TL;
         p = (c - 1) % TL + 1;
         s = t[0];
         @(posedge clk); #1;
         if (c == 4 * TL) begin req0 = 1'b0; req1 = 1'b0; end
         #1;
         expv = txn_exp(p, s, s ? 7'h5B : 7'h06);
         checks++;
         if (obs !== expv) $display("FAIL fairness c%0d got %h exp %h", c, obs, expv);
         else passed++;
         if (p == TL) $display("txn fairness #%0d: sel=%0d data=%h", t, mux_sel, lcd_data);
      end
   endtask

   task automatic test_single();
      req0 = 1'b1; data0 = 7'h3F;
      for (int c = 1; c <= TL; c++) begin
         @(posedge clk); #1;
         if (c == TL) req0 = 1'b0;
         #1;
         expv = txn_exp(c, 1'b0, 7'h3F);
         checks++;
         if (obs !== expv) $display("FAIL single c%0d got %h exp %h", c, obs, expv);
         else passed++;
      end
      $display("txn single: sel=%0d data=%h", mux_sel, lcd_data);
   endtask

   task automatic test_data_change();
      req0 = 1'b1; data0 = 7'h3F;
      for (int c = 1; c <= TL; c++) begin
         @(posedge clk); #1;
         if (c == 4) begin data0 = 7'h00; req0 = 1'b0; end
         #1;
         expv = txn_exp(c, 1'b0, 7'h3F);
         checks++;
         if (obs !== expv) $display("FAIL data_change c%0d got %h exp %h", c, obs, expv);
         else passed++;
      end
      $display("txn data_change: data=%h", lcd_data);
   endtask

   task automatic test_reset_mid();
      req0 = 1'b1; data0 = 7'h3F;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         if (c == 5) rst = 1'b1;
         #1;
         expv = (c == 5) ? 12'h000 : txn_exp(c, 1'b0, 7'h3F);
         checks++;
         if (obs !== expv) $display("FAIL reset_mid_pre c%0d got %h exp %h", c, obs, expv);
         else passed++;
      end
      #1 rst = 1'b0;
      for (int c = 1; c <= TL; c++) begin
         @(posedge clk); #1;
         if (c == TL) req0 = 1'b0;
         #1;
         expv = txn_exp(c, 1'b0, 7'h3F);
         checks++;
         if (obs !== expv) $display("FAIL reset_mid_post c%0d got %h exp %h", c, obs, expv);
         else passed++;
      end
      $display("txn reset_mid: restarted data=%h", lcd_data);
   endtask

`ifdef LCD_BUSY_WAIT_EN
   task automatic test_busy_wait();
      lcd_busy = 1'b1; req0 = 1'b1; data0 = 7'h2A;
      for (int c = 1; c <= 13; c++) begin
         @(posedge clk); #1;
         if (c == 12) lcd_busy = 1'b0;
         if (c == 13) req0 = 1'b0;
         #1;
         expv = {(c <= 12), (c >= 3 && c <= 6), 1'b0, (c == 12), 1'b0, 7'h2A};
         checks++;
         if (obs !== expv) $display("FAIL busy_wait c%0d got %h exp %h", c, obs, expv);
         else passed++;
      end
      $display("txn busy_wait: data=%h", lcd_data);
   endtask
`endif

   initial begin
      test_reset();
      test_simultaneous();
      test_fairness();
      test_single();
      test_data_change();
      test_reset_mid();
`ifdef LCD_BUSY_WAIT_EN
      test_busy_wait();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout after 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
